ser_link_arbiter: RTL
=====================

Name: ser_link_arbiter

Overview:
- Shares one serial output link between NREQ frame requesters.
- Picks a requester by round-robin and emits one complete frame for it: preamble 0111110, then ADDR_W address bits, then DATA_LEN payload bits pulled bit-by-bit from the grantee, then an idle gap.
- Sits upstream of the receiver-side sequence detector/controller. It guarantees idle-high line state and correct frame framing so the detector re-syncs after every frame.

Parameters:
- NREQ, 4, number of requesters (2..8).
- ADDR_W, 2, address bits sent after preamble, MSB first.
- DATA_LEN, 8, payload bits per frame.
- GAP_LEN, 2, idle-high cycles after payload (>=1).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  NREQ  per-requester frame request, level.
- req_addr  input  NREQ*ADDR_W  destination address; requester i uses slice [i*ADDR_W +: ADDR_W].
- bit_in  input  NREQ  per-requester current payload bit.
- bit_take  output  NREQ  one-hot pulse: grantee's bit_in is sampled this cycle; requester advances to its next bit after the edge.
- gnt  output  NREQ  one-hot registered grant, held for the whole frame.
- ser_out  output  1  serial link, registered, idle level 1.
- busy  output  1  state != IDLE.
- frame_done  output  1  single-cycle pulse in the last GAP cycle.

Behaviour:
- Reset (async) values:
  - state IDLE, gnt 0, bit_take 0, ser_out 1, busy 0, frame_done 0.
  - Round-robin pointer 0; bit counter 0.
  - Reset mid-frame aborts the frame immediately. The link returns high; the partial frame is not resumed.
- States: IDLE, PRE, ADDR, DATA, GAP.
- IDLE:
  - If any req bit is set: choose the first set bit at or after the pointer, wrapping modulo NREQ.
  - Register gnt one-hot and latch that requester's req_addr.
  - Next state PRE, counter 0.
  - Else stay in IDLE. Minimum 1 cycle in IDLE between frames.
- PRE: 7 cycles, bit k = PREAMBLE[6-k], PREAMBLE = 7'b0111110.
- ADDR: ADDR_W cycles, latched address MSB first.
- DATA:
  - DATA_LEN cycles; bit_take[g] = 1 combinationally every DATA cycle.
  - The selected bit is bit_in[g].
- GAP:
  - GAP_LEN cycles, bit 1.
  - frame_done asserts in the last GAP cycle. In that same cycle the pointer becomes (g+1) mod NREQ.
  - Then IDLE; gnt clears on entry to IDLE.
- ser_out register: loads the bit chosen in the current state at each edge, so the link lags the state by one cycle. It loads 1 in IDLE and GAP.
- Frame length on the link: 7+ADDR_W+DATA_LEN bits. Back-to-back period: 1+7+ADDR_W+DATA_LEN+GAP_LEN cycles (20 at defaults).
- req deassertion after grant is ignored; the frame always completes. req_addr changes after grant are ignored.
- New req arriving while busy waits for IDLE. There is no preemption.
- The payload is not escaped. Keeping 0111110 out of payload is the requester's responsibility.
- Counter width is clog2(max(7, ADDR_W, DATA_LEN, GAP_LEN)). The counter clears on every state change.

Decomposition:
- Package ser_link_pkg holds:
  - the state enum (IDLE, PRE, ADDR, DATA, GAP);
  - PREAMBLE = 7'b0111110 and PRE_LEN = 7;
  - IDLE_LEVEL = 1'b1.
- Sub-module rr_arbiter: combinational round-robin pick.
  - Inputs: req vector, pointer.
  - Outputs: one-hot grant and a valid flag.
- The FSM, counter, address latch and ser_out register stay in ser_link_arbiter.

Test Plan:
- Single frame, defaults: req[1]=1 at cycle 0 with addr 2'b10 and payload 0xA5 fed MSB first.
  - gnt=4'b0010 from cycle 1.
  - ser_out cycles 2..18 = 0111110 10 10100101.
  - bit_take[1] high cycles 10..17; frame_done at cycle 19; busy low at cycle 20.
- Round-robin: req=4'b1111 held.
  - Grants go 0,1,2,3,0.
  - Successive gnt rising edges are exactly 20 cycles apart.
  - Each requester sees exactly 8 bit_take pulses per frame.
- Pointer wrap/skip: req=4'b1001 held.
  - Grants alternate 0,3,0,3; requesters 1 and 2 never granted.
- req dropped: req[2] pulsed for one cycle only.
  - Full frame still sent with 8 bit_take[2] pulses; no second frame follows.
- Async reset mid-DATA: assert rst at the 3rd DATA cycle.
  - Same cycle: ser_out=1, gnt=0, busy=0, bit_take=0.
  - After release with req=4'b0110: the grant goes to requester 1 (pointer 0).
- Idle: req=0 for 50 cycles.
  - ser_out stays 1; gnt, bit_take, busy and frame_done stay 0.

Source files
------------

// File: rtl/ser_link_pkg.sv
// Shared types and constants for the serial link arbiter.
package ser_link_pkg;

  // Frame sequencer states.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    ADDR = 3'd2,
    DATA = 3'd3,
    GAP  = 3'd4
  } state_e;

  // Frame-start pattern, sent MSB first; the receiver re-syncs on it.
  localparam logic [6:0] PREAMBLE   = 7'b0111110;
  localparam int         PRE_LEN    = 7;
  localparam logic       IDLE_LEVEL = 1'b1;

  // Larger of two integers, used to size the shared phase counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ser_link_arbiter_rr.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter
  import ser_link_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int PTR_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt,
  output logic             valid
);

  logic [2*NREQ-1:0] req2_s;
  logic [2*NREQ-1:0] rot2_s;
  logic [NREQ-1:0]   rot_s;
  logic [NREQ-1:0]   pick_s;
  logic [2*NREQ-1:0] back_s;

  // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    req2_s = {req, req};
    rot2_s = req2_s >> ptr;
    rot_s  = rot2_s[NREQ-1:0];
    pick_s = rot_s & (~rot_s + {{(NREQ-1){1'b0}}, 1'b1});
    back_s = {{NREQ{1'b0}}, pick_s} << ptr;
    gnt    = back_s[NREQ-1:0] | back_s[2*NREQ-1:NREQ];
    valid  = |req;
  end

endmodule

// File: rtl/ser_link_arbiter.sv
// Round-robin sharing of one serial link: preamble, address, payload, idle gap.
module ser_link_arbiter
  import ser_link_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int ADDR_W   = 2,
  parameter int DATA_LEN = 8,
  parameter int GAP_LEN  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ-1:0]          bit_in,
  output logic [NREQ-1:0]          bit_take,
  output logic [NREQ-1:0]          gnt,
  output logic                     ser_out,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int PTR_W = $clog2(NREQ);
  localparam int CNT_W = $clog2(max_int(max_int(PRE_LEN, ADDR_W), max_int(DATA_LEN, GAP_LEN)));

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [NREQ-1:0]     gnt_q, gnt_d;
  logic [NREQ-1:0]     bit_take_q, bit_take_d;
  logic                ser_out_q, ser_out_d;
  logic                busy_q, busy_d;
  logic                frame_done_q, frame_done_d;

  logic [NREQ-1:0]     arb_gnt_s;
  logic                arb_valid_s;
  logic [ADDR_W-1:0]   addr_sel_s;
  logic [PTR_W-1:0]    ptr_next_s;
  logic [2:0]          pre_idx_s;

  rr_arbiter #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_rr (
    .req   (req),
    .ptr   (ptr_q),
    .gnt   (arb_gnt_s),
    .valid (arb_valid_s)
  );

  // Address of the requester being picked now, and the pointer slot after the current grantee.
  always_comb begin
    addr_sel_s = '0;
    ptr_next_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_gnt_s[i]) begin
        addr_sel_s = addr_sel_s | req_addr[i*ADDR_W +: ADDR_W];
      end else begin
        addr_sel_s = addr_sel_s;
      end
      if (gnt_q[i]) begin
        ptr_next_s = (i == NREQ - 1) ? '0 : PTR_W'(i + 1);
      end else begin
        ptr_next_s = ptr_next_s;
      end
    end
  end

  // Next-state logic: phase sequencing, bit selection and output pre-computation.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    ptr_d     = ptr_q;
    addr_d    = addr_q;
    gnt_d     = gnt_q;
    ser_out_d = IDLE_LEVEL;
    pre_idx_s = 3'(PRE_LEN - 1) - 3'(cnt_q);

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (arb_valid_s) begin
          state_d = PRE;
          gnt_d   = arb_gnt_s;
          addr_d  = addr_sel_s;
        end else begin
          gnt_d   = '0;
        end
      end
      PRE: begin
        ser_out_d = PREAMBLE[pre_idx_s];
        if (cnt_q == CNT_W'(PRE_LEN - 1)) begin
          state_d = ADDR;
          cnt_d   = '0;
        end else begin
          state_d = PRE;
        end
      end
      ADDR: begin
        // Shift the latched address out MSB first.
        ser_out_d = addr_q[ADDR_W-1];
        addr_d    = addr_q << 1;
        if (cnt_q == CNT_W'(ADDR_W - 1)) begin
          state_d = DATA;
          cnt_d   = '0;
        end else begin
          state_d = ADDR;
        end
      end
      DATA: begin
        ser_out_d = |(bit_in & gnt_q);
        if (cnt_q == CNT_W'(DATA_LEN - 1)) begin
          state_d = GAP;
          cnt_d   = '0;
        end else begin
          state_d = DATA;
        end
      end
      GAP: begin
        ser_out_d = IDLE_LEVEL;
        if (cnt_q == CNT_W'(GAP_LEN - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          gnt_d   = '0;
          ptr_d   = ptr_next_s;
        end else begin
          state_d = GAP;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        gnt_d   = '0;
      end
    endcase

    // Status outputs are registered from the upcoming state so they align with it.
    bit_take_d   = (state_d == DATA) ? gnt_d : '0;
    busy_d       = (state_d != IDLE);
    frame_done_d = (state_d == GAP) && (cnt_d == CNT_W'(GAP_LEN - 1));
  end

  // State, counter, pointer, address latch and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ptr_q        <= '0;
      addr_q       <= '0;
      gnt_q        <= '0;
      bit_take_q   <= '0;
      ser_out_q    <= IDLE_LEVEL;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ptr_q        <= ptr_d;
      addr_q       <= addr_d;
      gnt_q        <= gnt_d;
      bit_take_q   <= bit_take_d;
      ser_out_q    <= ser_out_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign gnt        = gnt_q;
  assign bit_take   = bit_take_q;
  assign ser_out    = ser_out_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule
